// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_pkg
// Brief    : Shared sizes and grant encodings for the write-back arbiter.
// Revision : 1.0
// ============================================================================
package reg_write_arbiter_pkg;

    localparam int unsigned c_DATA_W   = 8;
    localparam int unsigned c_NUM_REGS = 4;
    localparam int unsigned c_ADDR_W   = 2;

    // Encoding of the round-robin "last granted" pointer
    localparam logic c_GNT_ALU = 1'b0;
    localparam logic c_GNT_MEM = 1'b1;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_ALU  = 2'b01,
        GRANT_MEM  = 2'b10
    } grant_e;

endpackage : reg_write_arbiter_pkg
`default_nettype wire

// File: rtl/reg_write_arbiter_wb_slot.sv
`default_nettype none
// ============================================================================
// Module   : wb_slot
// Brief    : One-entry request holding register with valid/ready and pop.
// Revision : 1.0
// ============================================================================
module wb_slot #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;

    // A slot being drained this cycle can take a new entry on the same edge
    assign o_ready  = !r_full || i_pop;
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            if (w_accept) begin
                r_full <= 1'b1;
                r_addr <= i_addr;
                r_data <= i_data;
            end else if (i_pop) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule : wb_slot
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Round-robin write-back arbiter (ALU vs load) driving a one-hot
//            register write strobe and shared data bus.
// Revision : 1.0
// ============================================================================
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = c_DATA_W,
    parameter int unsigned NUM_REGS = c_NUM_REGS,
    parameter int unsigned ADDR_W   = c_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_alu_valid,
    output logic                o_alu_ready,
    input  logic [ADDR_W-1:0]   i_alu_addr,
    input  logic [DATA_W-1:0]   i_alu_data,
    input  logic                i_mem_valid,
    output logic                o_mem_ready,
    input  logic [ADDR_W-1:0]   i_mem_addr,
    input  logic [DATA_W-1:0]   i_mem_data,
    output logic [NUM_REGS-1:0] o_wr,
    output logic [DATA_W-1:0]   o_data,
    output logic                o_busy
);

    logic                w_alu_full;
    logic [ADDR_W-1:0]   w_alu_addr;
    logic [DATA_W-1:0]   w_alu_data;
    logic                w_mem_full;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_data;

    grant_e              w_grant;
    logic                w_pop_alu;
    logic                w_pop_mem;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REGS-1:0] w_wr_dec;

    logic                r_last;
    logic [NUM_REGS-1:0] r_wr;
    logic [DATA_W-1:0]   r_data;

    wb_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_slot_alu (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_alu_valid),
        .o_ready (o_alu_ready),
        .i_addr  (i_alu_addr),
        .i_data  (i_alu_data),
        .i_pop   (w_pop_alu),
        .o_full  (w_alu_full),
        .o_addr  (w_alu_addr),
        .o_data  (w_alu_data)
    );

    wb_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_slot_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_mem_valid),
        .o_ready (o_mem_ready),
        .i_addr  (i_mem_addr),
        .i_data  (i_mem_data),
        .i_pop   (w_pop_mem),
        .o_full  (w_mem_full),
        .o_addr  (w_mem_addr),
        .o_data  (w_mem_data)
    );

    // Contested cycles go to whichever producer did not win the last grant
    always_comb begin
        w_grant = GRANT_NONE;
        if (w_alu_full && w_mem_full) begin
            w_grant = (r_last == c_GNT_ALU) ? GRANT_MEM : GRANT_ALU;
        end else if (w_alu_full) begin
            w_grant = GRANT_ALU;
        end else if (w_mem_full) begin
            w_grant = GRANT_MEM;
        end
    end

    assign w_pop_alu  = (w_grant == GRANT_ALU);
    assign w_pop_mem  = (w_grant == GRANT_MEM);
    assign w_sel_addr = w_pop_mem ? w_mem_addr : w_alu_addr;
    assign w_sel_data = w_pop_mem ? w_mem_data : w_alu_data;

    // Indices beyond the bank decode to no strobe, so such requests vanish
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_wr_dec
        assign w_wr_dec[k] = (w_grant != GRANT_NONE) && (int'(w_sel_addr) == k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr   <= '0;
            r_data <= '0;
            r_last <= c_GNT_ALU;
        end else begin
            r_wr <= w_wr_dec;
            if (w_grant != GRANT_NONE) begin
                r_data <= w_sel_data;
                r_last <= w_pop_mem ? c_GNT_MEM : c_GNT_ALU;
            end
        end
    end

    assign o_wr   = r_wr;
    assign o_data = r_data;
    assign o_busy = w_alu_full || w_mem_full || (|r_wr);

endmodule : reg_write_arbiter
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Brief    : Scoreboard bench with a transaction-level model of the arbiter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_reg_write_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_alu_valid, i_mem_valid;
    logic          o_alu_ready, o_mem_ready;
    logic [AW-1:0] i_alu_addr, i_mem_addr;
    logic [DW-1:0] i_alu_data, i_mem_data;
    logic [NR-1:0] o_wr;
    logic [DW-1:0] o_data;
    logic          o_busy;

    always #5 clk = ~clk;

    reg_write_arbiter #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_alu_valid (i_alu_valid),
        .o_alu_ready (o_alu_ready),
        .i_alu_addr  (i_alu_addr),
        .i_alu_data  (i_alu_data),
        .i_mem_valid (i_mem_valid),
        .o_mem_ready (o_mem_ready),
        .i_mem_addr  (i_mem_addr),
        .i_mem_data  (i_mem_data),
        .o_wr        (o_wr),
        .o_data      (o_data),
        .o_busy      (o_busy)
    );

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
    typedef struct { int e; logic [NR-1:0] wr; logic [AW-1:0] addr; logic [DW-1:0] data; } exp_t;

    int total = 0;
    int bad   = 0;

    req_t          alu_src[$], mem_src[$];   // requests waiting to be offered
    req_t          pend_a[$], pend_m[$];     // model: accepted, not yet written
    exp_t          expq[$];                  // scoreboard
    bit            last_mem = 1'b0;
    bit            acc_a, acc_m;
    int            acc_edge_a;
    int            edge_no = 0;
    int            gap_pct = 0;
    logic [DW-1:0] bank_model [NR];
    logic [DW-1:0] bank_seen  [NR];
    logic [NR-1:0] wr_log[$];
    int            strobe_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 0 = nobody, 1 = ALU, 2 = MEM
    function automatic int pick();
        if (pend_a.size() > 0 && pend_m.size() > 0) return last_mem ? 1 : 2;
        if (pend_a.size() > 0) return 1;
        if (pend_m.size() > 0) return 2;
        return 0;
    endfunction

    // Reference model, advanced once per rising edge
    int   m_g;
    req_t m_r;
    exp_t m_e;
    always @(posedge clk) begin
        edge_no++;
        acc_a = 1'b0;
        acc_m = 1'b0;
        if (rst_n) begin
            m_g = pick();
            if (m_g != 0) begin
                if (m_g == 1) m_r = pend_a.pop_front();
                else          m_r = pend_m.pop_front();
                m_e.e    = edge_no;
                m_e.addr = m_r.addr;
                m_e.data = m_r.data;
                m_e.wr   = '0;
                if (int'(m_r.addr) < NR) m_e.wr[m_r.addr] = 1'b1;
                expq.push_back(m_e);
                last_mem = (m_g == 2);
            end
            if (i_alu_valid && pend_a.size() == 0) begin
                m_r.addr = i_alu_addr; m_r.data = i_alu_data;
                pend_a.push_back(m_r);
                acc_a = 1'b1;
                acc_edge_a = edge_no;
            end
            if (i_mem_valid && pend_m.size() == 0) begin
                m_r.addr = i_mem_addr; m_r.data = i_mem_data;
                pend_m.push_back(m_r);
                acc_m = 1'b1;
            end
        end
        for (int k = 0; k < NR; k++)
            if (o_wr[k]) bank_seen[k] = o_data;
    end

    always @(negedge rst_n) begin
        pend_a.delete();
        pend_m.delete();
        expq.delete();
        last_mem = 1'b0;
    end

    // Monitor: every settled cycle either carries the scheduled write or none
    exp_t    mon_e;
    logic    mon_strobe;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_strobe = 1'b0;
            if (expq.size() > 0 && expq[0].e <= edge_no) begin
                mon_e = expq.pop_front();
                check("strobe_time", mon_e.e, edge_no);
                check("strobe_wr", o_wr, mon_e.wr);
                if (mon_e.wr != '0) begin
                    check("strobe_data", o_data, mon_e.data);
                    bank_model[mon_e.addr] = mon_e.data;
                    mon_strobe = 1'b1;
                end
            end else begin
                check("idle_wr", o_wr, '0);
            end
            check("alu_ready", o_alu_ready, (pend_a.size() == 0 || pick() == 1));
            check("mem_ready", o_mem_ready, (pend_m.size() == 0 || pick() == 2));
            check("busy", o_busy, (pend_a.size() > 0 || pend_m.size() > 0 || mon_strobe));
            if (o_wr != '0) begin
                wr_log.push_back(o_wr);
                strobe_log.push_back(edge_no);
            end
        end
    end

    // Producer driver: holds each request until the model says it was taken
    req_t d_r;
    always @(negedge clk) begin
        if (!rst_n) begin
            i_alu_valid = 1'b0;
            i_mem_valid = 1'b0;
        end else begin
            if (acc_a) i_alu_valid = 1'b0;
            if (acc_m) i_mem_valid = 1'b0;
            if (!i_alu_valid && alu_src.size() > 0 && $urandom_range(99) >= gap_pct) begin
                d_r = alu_src.pop_front();
                i_alu_valid = 1'b1; i_alu_addr = d_r.addr; i_alu_data = d_r.data;
            end
            if (!i_mem_valid && mem_src.size() > 0 && $urandom_range(99) >= gap_pct) begin
                d_r = mem_src.pop_front();
                i_mem_valid = 1'b1; i_mem_addr = d_r.addr; i_mem_data = d_r.data;
            end
        end
    end

    task automatic push_alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r; r.addr = a; r.data = d; alu_src.push_back(r);
    endtask

    task automatic push_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r; r.addr = a; r.data = d; mem_src.push_back(r);
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk); #1;
        while (n < 4000 && !(alu_src.size() == 0 && mem_src.size() == 0 && !i_alu_valid &&
               !i_mem_valid && pend_a.size() == 0 && pend_m.size() == 0 && expq.size() == 0)) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_in_time", (n < 4000), 1);
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int k = 0; k < NR; k++) begin bank_model[k] = '0; bank_seen[k] = '0; end
        rst_n = 1'b1;
        i_alu_valid = 1'b0; i_mem_valid = 1'b0;
        i_alu_addr = '0; i_mem_addr = '0; i_alu_data = '0; i_mem_data = '0;

        // Asynchronous reset assertion between clock edges
        #1 rst_n = 1'b0;
        #1;
        check("rst_wr", o_wr, '0);
        check("rst_data", o_data, '0);
        check("rst_alu_ready", o_alu_ready, 1);
        check("rst_mem_ready", o_mem_ready, 1);
        check("rst_busy", o_busy, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Single ALU write
        push_alu(2'd2, 8'h5A);
        wait_drain();
        check("t2_reg2", bank_seen[2], 8'h5A);

        // Contested first arbitration goes to memory
        wr_log.delete();
        push_alu(2'd1, 8'h11);
        push_mem(2'd3, 8'h33);
        wait_drain();
        check("t3_first_wr", wr_log[0], 4'b1000);
        check("t3_second_wr", wr_log[1], 4'b0010);
        check("t3_reg3", bank_seen[3], 8'h33);
        check("t3_reg1", bank_seen[1], 8'h11);

        // Back-to-back contention: strict alternation, no bubbles
        wr_log.delete();
        strobe_log.delete();
        for (int i = 0; i < 6; i++) begin
            push_alu(AW'(i % 4), DW'(8'hA0 + i));
            push_mem(AW'((i + 1) % 4), DW'(8'hC0 + i));
        end
        wait_drain();
        check("t4_count", wr_log.size(), 12);
        check("t4_span", strobe_log[11] - strobe_log[0], 11);
        for (int i = 0; i < 6; i++) begin
            check("t4_mem_order", wr_log[2*i],     NR'(1) << ((i + 1) % 4));
            check("t4_alu_order", wr_log[2*i + 1], NR'(1) << (i % 4));
        end

        // Same target: both writes issue, later one wins
        wr_log.delete();
        push_mem(2'd0, 8'hAA);
        push_alu(2'd0, 8'hBB);
        wait_drain();
        check("t5_pulses", wr_log.size(), 2);
        check("t5_first", wr_log[0], 4'b0001);
        check("t5_second", wr_log[1], 4'b0001);
        check("t5_reg0", bank_seen[0], 8'hBB);

        // Reset while both slots hold requests
        push_alu(2'd2, 8'h22);
        push_mem(2'd1, 8'h44);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(acc_a && acc_m) && n < 20);
        check("t6_both_full", (acc_a && acc_m), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_wr", o_wr, '0);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_alu_ready", o_alu_ready, 1);
        check("t6_rst_mem_ready", o_mem_ready, 1);
        wr_log.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("t6_no_strobe", wr_log.size(), 0);
        check("t6_idle_busy", o_busy, 0);
        strobe_log.delete();
        push_alu(2'd3, 8'hC3);
        wait_drain();
        check("t6_fresh_count", strobe_log.size(), 1);
        check("t6_latency", strobe_log[0] - acc_edge_a, 1);
        check("t6_reg3", bank_seen[3], 8'hC3);

        // Randomised traffic with random valid gaps
        gap_pct = 40;
        for (int i = 0; i < 200; i++) begin
            push_alu(AW'($urandom_range(NR - 1)), DW'($urandom));
            push_mem(AW'($urandom_range(NR - 1)), DW'($urandom));
        end
        wait_drain();

        for (int k = 0; k < NR; k++)
            check("final_bank", bank_seen[k], bank_model[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule : tb_reg_write_arbiter
`default_nettype wire
